// File: rtl/corescore_emitter_uart.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | corescore_emitter_uart: 8N1 UART transmitter, one byte per valid/ready     |
// | handshake.                                                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module corescore_emitter_uart #(
   parameter int clk_freq_hz = 50000000,
   parameter int baud_rate   = 57600
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_uart_tx
);

   localparam int DIV = clk_freq_hz / baud_rate;
   localparam int c_BAUD_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [c_BAUD_W-1:0] c_BAUD_MAX = c_BAUD_W'(DIV - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t              r_state = S_IDLE;
   logic                r_ready = 1'b1;
   logic                r_tx    = 1'b1;
   logic [8:0]          r_shift = '0;
   logic [3:0]          r_bit_cnt = '0;
   logic [c_BAUD_W-1:0] r_baud  = '0;

   // r_shift holds the bits still to be sent after the one currently on the
   // line (data LSB first, then the stop bit).
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_ready   <= 1'b1;
         r_tx      <= 1'b1;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_baud    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_valid) begin
                  r_state   <= S_BUSY;
                  r_ready   <= 1'b0;
                  r_tx      <= 1'b0;
                  r_shift   <= {1'b1, i_data};
                  r_bit_cnt <= 4'd9;
                  r_baud    <= c_BAUD_MAX;
               end
            end
            S_BUSY: begin
               if (r_baud != '0) begin
                  r_baud <= r_baud - 1'b1;
               end else if (r_bit_cnt == 4'd0) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
                  r_tx    <= 1'b1;
               end else begin
                  r_tx      <= r_shift[0];
                  r_shift   <= {1'b0, r_shift[8:1]};
                  r_bit_cnt <= r_bit_cnt - 1'b1;
                  r_baud    <= c_BAUD_MAX;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   assign o_ready   = r_ready;
   assign o_uart_tx = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_corescore_emitter_uart.sv
`default_nettype none
// Testbench for corescore_emitter_uart: two instances (DIV=10 and DIV=3)
// compared every cycle against a frame-expansion scoreboard.
module tb_corescore_emitter_uart;

   localparam int DIVA = 615000 / 56000;
   localparam int DIVB = 1000 / 300;

   logic       clk = 1'b0;
   logic       resetn;
   logic [7:0] a_data, b_data;
   logic       a_valid, b_valid;
   logic       a_ready, a_tx, b_ready, b_tx;

   int n_tests = 0;
   int n_fail  = 0;

   logic [1:0] qa[$];
   logic [1:0] qb[$];
   logic       a_mready, b_mready;

   always #5 clk = ~clk;

   corescore_emitter_uart #(.clk_freq_hz(615000), .baud_rate(56000)) u_dut_a (
      .clk      (clk),
      .resetn   (resetn),
      .i_data   (a_data),
      .i_valid  (a_valid),
      .o_ready  (a_ready),
      .o_uart_tx(a_tx)
   );

   corescore_emitter_uart #(.clk_freq_hz(1000), .baud_rate(300)) u_dut_b (
      .clk      (clk),
      .resetn   (resetn),
      .i_data   (b_data),
      .i_valid  (b_valid),
      .o_ready  (b_ready),
      .o_uart_tx(b_tx)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // One clock: decide acceptance from the inputs and the previous expected
   // ready, expand accepted bytes into per-cycle line values, then compare.
   task automatic tick();
      logic [1:0] ea, eb;
      logic [9:0] fa, fb;
      logic       acc_a, acc_b;
      acc_a = resetn && a_valid && a_mready;
      acc_b = resetn && b_valid && b_mready;
      fa = {1'b1, a_data, 1'b0};
      fb = {1'b1, b_data, 1'b0};
      @(posedge clk);
      if (!resetn) begin
         qa.delete();
         qb.delete();
      end
      if (acc_a) for (int i = 0; i < 10 * DIVA; i++) qa.push_back({1'b0, fa[i / DIVA]});
      if (acc_b) for (int i = 0; i < 10 * DIVB; i++) qb.push_back({1'b0, fb[i / DIVB]});
      ea = (qa.size() > 0) ? qa.pop_front() : 2'b11;
      eb = (qb.size() > 0) ? qb.pop_front() : 2'b11;
      a_mready = ea[1];
      b_mready = eb[1];
      #1;
      check_eq("a_ready", {31'd0, a_ready}, {31'd0, ea[1]});
      check_eq("a_tx",    {31'd0, a_tx},    {31'd0, ea[0]});
      check_eq("b_ready", {31'd0, b_ready}, {31'd0, eb[1]});
      check_eq("b_tx",    {31'd0, b_tx},    {31'd0, eb[0]});
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      resetn   = 1'b1;
      a_valid  = 1'b0;
      b_valid  = 1'b0;
      a_data   = 8'h00;
      b_data   = 8'h00;
      a_mready = 1'b1;
      b_mready = 1'b1;

      #1;
      check_eq("pwrup_a_ready", {31'd0, a_ready}, 32'd1);
      check_eq("pwrup_a_tx",    {31'd0, a_tx},    32'd1);
      check_eq("pwrup_b_ready", {31'd0, b_ready}, 32'd1);
      check_eq("pwrup_b_tx",    {31'd0, b_tx},    32'd1);

      resetn = 1'b0;
      ticks(2);
      resetn = 1'b1;

      // Basic 0x41 frame with a 0xFF pulse at cycle 35 that must be ignored
      a_valid = 1'b1; a_data = 8'h41;
      tick();
      a_valid = 1'b0;
      ticks(33);
      a_valid = 1'b1; a_data = 8'hFF;
      tick();
      a_valid = 1'b0; a_data = 8'h00;
      ticks(90);

      // Back-to-back with i_valid held: 0x00 then 0x55
      a_valid = 1'b1; a_data = 8'h00;
      tick();
      a_data = 8'h55;
      ticks(10 * DIVA + 1);
      a_valid = 1'b0;
      ticks(10 * DIVA + 10);

      // Reset at cycle 47 of a 0x00 frame
      a_valid = 1'b1; a_data = 8'h00;
      tick();
      a_valid = 1'b0;
      ticks(45);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      ticks(40);

      // Valid during reset ignored, accepted on the first edge after release
      resetn = 1'b0; a_valid = 1'b1; a_data = 8'h3C;
      tick();
      resetn = 1'b1;
      tick();
      a_valid = 1'b0; a_data = 8'hC3;
      ticks(10 * DIVA + 5);

      // DIV=3 truncation: 0xA5, then back-to-back 0x5A / 0x81
      b_valid = 1'b1; b_data = 8'hA5;
      tick();
      b_valid = 1'b0;
      ticks(35);
      b_valid = 1'b1; b_data = 8'h5A;
      tick();
      b_data = 8'h81;
      ticks(10 * DIVB + 1);
      b_valid = 1'b0;
      ticks(10 * DIVB + 5);

      // Mixed random traffic on both instances
      for (int k = 0; k < 300; k++) begin
         a_valid = 1'($urandom_range(0, 7) == 0);
         b_valid = 1'($urandom_range(0, 3) == 0);
         a_data  = 8'($urandom);
         b_data  = 8'($urandom);
         tick();
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      ticks(10 * DIVA + 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
